// File: rtl/avln_pkt_gen.sv
// avln_pkt_gen: Avalon-ST test packet source for board bring-up and loopback.
// Emits framed packets with byte i = (seq + i) mod 256, length/gap/run/pause
// taken from the board switches. Output is fully registered, no backpressure.
// Optional build macro: AVLN_PKT_GEN_BUBBLE_EN adds pseudo-random valid bubbles
// inside packets (16-bit LFSR, taps 16,14,13,11, seed 16'hACE1).
//
// Stream handshake: out.valid qualifies a beat; there is no ready, so every
// cycle with out.valid=1 is a transferred beat. When out.valid=0, sop/eop/empty
// are 0 and data holds its previous value.

package avln_pkg;
   localparam int AVLN_DATA_BYTES = 8;
   localparam int AVLN_EMPTY_W    = $clog2(AVLN_DATA_BYTES);

   typedef struct packed {
      logic [AVLN_DATA_BYTES*8-1:0] data;
      logic                         sop;
      logic                         eop;
      logic [AVLN_EMPTY_W-1:0]      empty;
      logic                         valid;
   } avln_st;
endpackage

module avln_pkt_gen
   import avln_pkg::*;
#(
   parameter int DATA_BYTES = AVLN_DATA_BYTES,
   parameter int MIN_LEN    = 64
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic [17:0] SW,
   output avln_st      out,
   output logic [1:0]  dbg_state
);

   localparam int          EW         = $clog2(DATA_BYTES);
   localparam logic [10:0] MIN_LEN_L  = 11'(MIN_LEN);
   localparam logic [10:0] BEAT_BYTES = 11'(DATA_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] len_q, len_d;     // latched packet length in bytes
   logic [8:0]  beat_q, beat_d;   // beat index within the packet
   logic [10:0] byte_q, byte_d;   // packet byte offset of the current beat
   logic [15:0] seq_q, seq_d;     // packet sequence number
   logic [4:0]  gap_q, gap_d;     // remaining gap cycles
   avln_st      out_q, out_d;

   logic                    run;
   logic                    pause;
   logic                    stall;
   logic                    last_beat;
   logic [10:0]             sw_len;
   logic [10:0]             req_len;
   logic [4:0]              sw_gap;
   logic [EW-1:0]           len_lo;
   logic [DATA_BYTES*8-1:0] beat_data;

   assign run     = SW[0];
   assign pause   = SW[1];
   assign sw_len  = SW[12:2];
   assign sw_gap  = SW[17:13];
   assign req_len = (sw_len < MIN_LEN_L) ? MIN_LEN_L : sw_len;

   // byte_q is always a whole number of beats, so the last beat's empty count
   // is just (-LEN) modulo DATA_BYTES (DATA_BYTES is a power of two).
   assign last_beat = ({1'b0, byte_q} + {1'b0, BEAT_BYTES}) >= {1'b0, len_q};
   assign len_lo    = len_q[EW-1:0];

`ifdef AVLN_PKT_GEN_BUBBLE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR step, advancing every cycle
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR register, reseeded on reset
   always_ff @(posedge sys_clk) begin
      if (!reset_n) lfsr_q <= 16'hACE1;
      else          lfsr_q <= lfsr_d;
   end

   assign stall = pause | (lfsr_q[1:0] == 2'b00);
`else
   assign stall = pause;
`endif

   // Pattern bytes for the current beat; byte 0 of the beat lands in the MSB lane
   always_comb begin
      beat_data = '0;
      for (int j = 0; j < DATA_BYTES; j++) begin
         if (({1'b0, byte_q} + 12'(j)) < {1'b0, len_q})
            beat_data[(DATA_BYTES-1-j)*8 +: 8] = seq_q[7:0] + byte_q[7:0] + 8'(j);
      end
   end

   // Next-state and next-output logic for the IDLE/SEND/GAP sequencer
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      beat_d         = beat_q;
      byte_d         = byte_q;
      seq_d          = seq_q;
      gap_d          = gap_q;
      out_d          = '0;
      out_d.data     = out_q.data;

      case (state_q)
         IDLE: begin
            if (run) begin
               len_d   = req_len;
               beat_d  = '0;
               byte_d  = '0;
               state_d = SEND;
            end
         end

         SEND: begin
            if (!stall) begin
               out_d.valid = 1'b1;
               out_d.data  = beat_data;
               out_d.sop   = (beat_q == 9'd0);
               out_d.eop   = last_beat;
               out_d.empty = last_beat ? ({EW{1'b0}} - len_lo) : '0;
               if (last_beat) begin
                  seq_d  = seq_q + 16'd1;
                  beat_d = '0;
                  byte_d = '0;
                  gap_d  = sw_gap;
                  if (sw_gap != 5'd0) begin
                     state_d = GAP;
                  end else if (run) begin
                     len_d   = req_len;
                     state_d = SEND;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_d = beat_q + 9'd1;
                  byte_d = byte_q + BEAT_BYTES;
               end
            end
         end

         GAP: begin
            gap_d = gap_q - 5'd1;
            if (gap_q <= 5'd1) begin
               if (run) begin
                  len_d   = req_len;
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered stream output
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         beat_q  <= '0;
         byte_q  <= '0;
         seq_q   <= '0;
         gap_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         byte_q  <= byte_d;
         seq_q   <= seq_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
      end
   end

   assign out       = out_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_avln_pkt_gen.sv
// Bench for avln_pkt_gen: randomized switch settings, a packet-level reference
// model filling an expected-beat queue, and a monitor that checks every output
// cycle (beats, idle fields, held data, inter-packet gap length).

module tb_avln_pkt_gen;
   import avln_pkg::*;

   localparam int DB = 8;
   localparam int W  = DB*8 + 2 + 3;

`ifdef AVLN_PKT_GEN_BUBBLE_EN
   localparam bit GAP_EXACT = 1'b0;
`else
   localparam bit GAP_EXACT = 1'b1;
`endif

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic [17:0] SW;
   avln_st      out;
   logic [1:0]  dbg_state;

   avln_pkt_gen #(.DATA_BYTES(DB), .MIN_LEN(64)) dut (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .SW        (SW),
      .out       (out),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 sys_clk = ~sys_clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0]  exp_q[$];
   int            exp_gap_q[$];
   logic [63:0]   last_exp_data;
   int            n_checks;
   int            n_fail;
   int            sop_cnt;
   int            eop_cnt;
   int            idle_cnt;
   int            seq_m;
   bit            mon_en;

   // Reference model: expected beats of one packet from its seq and requested length
   function automatic void push_packet(input int seq, input int len, input int gap_exp);
      int           l;
      int           beats;
      logic [63:0]  d;
      logic [W-1:0] e;
      l     = (len < 64) ? 64 : len;
      beats = (l + DB - 1) / DB;
      for (int b = 0; b < beats; b++) begin
         d = '0;
         for (int j = 0; j < DB; j++) begin
            int k;
            k = b*DB + j;
            if (k < l) d[63-8*j -: 8] = 8'((seq + k) % 256);
         end
         e = {d, (b == 0), (b == beats-1), 3'((b == beats-1) ? (beats*DB - l) : 0)};
         exp_q.push_back(e);
      end
      exp_gap_q.push_back(gap_exp);
   endfunction

   // ---------------- monitor ----------------
   always @(negedge sys_clk) begin
      logic [W-1:0] act;
      logic [W-1:0] ex;
      int           g;
      if (mon_en) begin
         if (out.valid) begin
            act = {out.data, out.sop, out.eop, out.empty};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL beat: got unexpected beat %h, expected none", act);
            end else begin
               ex = exp_q.pop_front();
               last_exp_data = ex[W-1:5];
               if (act !== ex) begin
                  n_fail++;
                  $display("FAIL beat: got %h expected %h (data,sop,eop,empty)", act, ex);
               end
            end
            if (out.sop) begin
               sop_cnt++;
               if (exp_gap_q.size() > 0) begin
                  g = exp_gap_q.pop_front();
                  if (g >= 0) begin
                     n_checks++;
                     if (idle_cnt != g) begin
                        n_fail++;
                        $display("FAIL gap: got %0d idle cycles expected %0d", idle_cnt, g);
                     end
                  end
               end
            end
            if (out.eop) begin
               eop_cnt++;
               idle_cnt = 0;
            end
         end else begin
            n_checks++;
            if (out.sop || out.eop || (out.empty != '0) || (out.data !== last_exp_data)) begin
               n_fail++;
               $display("FAIL idle_fields: got sop=%b eop=%b empty=%0d data=%h expected 0 0 0 data=%h",
                        out.sop, out.eop, out.empty, out.data, last_exp_data);
            end
            idle_cnt++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_idle_end(input string tag);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_leftover: got %0d beats still expected, expected 0", tag, exp_q.size());
      end
      n_checks++;
      if (dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL %s_state: got state %0d expected 0 (IDLE)", tag, dbg_state);
      end
      exp_q.delete();
      exp_gap_q.delete();
   endtask

   task automatic run_scn(input int len, input int gap, input int npk,
                          input bit pause_en, input bit scribble);
      int sop_tgt;
      int eop_tgt;
      int cyc;
      int budget;
      sop_tgt = sop_cnt + npk;
      eop_tgt = eop_cnt + npk;
      for (int p = 0; p < npk; p++) begin
         push_packet(seq_m, len, (p == 0 || pause_en || !GAP_EXACT) ? -1 : gap);
         seq_m = (seq_m + 1) % 65536;
      end
      @(posedge sys_clk); #1;
      SW     = {5'(gap), 11'(len), 1'b0, 1'b1};
      budget = npk * (1200 + gap) + 100;
      cyc    = 0;
      while (sop_cnt < sop_tgt && cyc < budget) begin
         @(posedge sys_clk); #1;
         if (pause_en) SW[1] = ($urandom_range(0, 2) == 0);
         cyc++;
      end
      // run drops during the final packet: it must still complete
      SW[0] = 1'b0;
      if (scribble) begin
         SW[12:2]  = 11'($urandom_range(0, 2047));
         SW[17:13] = 5'($urandom_range(0, 31));
      end
      while (eop_cnt < eop_tgt && cyc < budget) begin
         @(posedge sys_clk); #1;
         if (pause_en) SW[1] = ($urandom_range(0, 2) == 0);
         cyc++;
      end
      SW[1] = 1'b0;
      n_checks++;
      if (cyc >= budget) begin
         n_fail++;
         $display("FAIL scn_timeout: got %0d/%0d eops after %0d cycles, expected all", eop_cnt, eop_tgt, cyc);
      end
      repeat (40) @(posedge sys_clk);
      #1;
      check_idle_end("scn");
   endtask

   task automatic reset_test();
      int cyc;
      int tgt;
      push_packet(seq_m, 64, -1);
      tgt = sop_cnt + 1;
      @(posedge sys_clk); #1;
      SW  = {5'd0, 11'd64, 1'b0, 1'b1};
      cyc = 0;
      while (sop_cnt < tgt && cyc < 100) begin
         @(posedge sys_clk); #1;
         cyc++;
      end
      n_checks++;
      if (cyc >= 100) begin
         n_fail++;
         $display("FAIL rst_sop_timeout: got no sop in %0d cycles, expected one", cyc);
      end
      repeat (3) @(posedge sys_clk);
      #1;
      reset_n = 1'b0;
      SW[0]   = 1'b0;
      @(posedge sys_clk); #1;
      n_checks++;
      if (out !== '0) begin
         n_fail++;
         $display("FAIL rst_out: got %h expected 0", out);
      end
      n_checks++;
      if (dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_state: got %0d expected 0", dbg_state);
      end
      exp_q.delete();
      exp_gap_q.delete();
      last_exp_data = '0;
      seq_m         = 0;
      @(posedge sys_clk); #1;
      reset_n = 1'b1;
      run_scn(64, 2, 2, 1'b0, 1'b0);
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      n_checks      = 0;
      n_fail        = 0;
      sop_cnt       = 0;
      eop_cnt       = 0;
      idle_cnt      = 0;
      seq_m         = 0;
      mon_en        = 1'b0;
      last_exp_data = '0;
      reset_n       = 1'b0;
      SW            = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      n_checks++;
      if (out !== '0) begin
         n_fail++;
         $display("FAIL init_out: got %h expected 0", out);
      end
      n_checks++;
      if (dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL init_state: got %0d expected 0", dbg_state);
      end
      mon_en  = 1'b1;
      reset_n = 1'b1;

      run_scn(64,   0,  3, 1'b0, 1'b0);   // back-to-back, seq 0..2
      run_scn(65,   0,  2, 1'b0, 1'b0);   // 9 beats, empty=7
      run_scn(10,   5,  2, 1'b0, 1'b0);   // clamp to MIN_LEN, gap 5
      run_scn(64,   31, 2, 1'b0, 1'b0);   // max gap
      run_scn(0,    3,  2, 1'b0, 1'b1);   // zero length clamps
      run_scn(2047, 1,  1, 1'b0, 1'b1);   // max length, 256 beats
      run_scn(100,  2,  3, 1'b1, 1'b0);   // pause stalls
      reset_test();
      for (int i = 0; i < 8; i++) begin
         run_scn($urandom_range(0, 300), $urandom_range(0, 31), $urandom_range(1, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
